// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle between a controller and the nibble-serial adder sequencer.
// master issues start with operands; slave reports busy/done and the held result.
interface nibble_serial_adder_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output start, sub, a, b, c_in,
    input  busy, done, sum, c_out, overflow
  );

  modport slave (
    input  start, sub, a, b, c_in,
    output busy, done, sum, c_out, overflow
  );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit add/sub on one shared 4-bit ripple slice, LSB nibble first; latency NIB+1.
// No backpressure: start is only taken in IDLE/DONE, ignored (not queued) while busy.
module fulladd4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);
  logic [4:0] c;

  assign c[0] = c_in;
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign c_out = c[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                       clk,
  input logic                       reset,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_bad_width
    $error("nibble_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic              accept;
  logic              last_step;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  sum_q;
  logic              c_out_q;
  logic              ovf_q;
  logic [3:0]        a_nib;
  logic [3:0]        b_nib;
  logic [3:0]        add_sum;
  logic              add_co;

  assign last_step = (idx_q == IDXW'(NIB - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // DONE accepts a new start just like IDLE so operations can run back to back.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int k = 0; k < NIB; k++) begin
      if (idx_q == IDXW'(k)) begin
        a_nib = a_q[4*k +: 4];
        b_nib = b_q[4*k +: 4];
      end
    end
  end

  fulladd4 u_slice (
    .a     (a_nib),
    .b     (b_nib),
    .c_in  (carry_q),
    .sum   (add_sum),
    .c_out (add_co)
  );

  // B is stored pre-inverted for subtract so the slice only ever adds.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= '0;
      a_q     <= bus.a;
      b_q     <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub ? 1'b1 : bus.c_in;
    end else if (state_q == RUN) begin
      for (int k = 0; k < NIB; k++) begin
        if (idx_q == IDXW'(k)) sum_q[4*k +: 4] <= add_sum;
      end
      carry_q <= add_co;
      if (last_step) begin
        c_out_q <= add_co;
        ovf_q   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[3] != a_q[WIDTH-1]);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.sum      = sum_q;
  assign bus.c_out    = c_out_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Randomized scoreboard bench for nibble_serial_adder_ctrl at WIDTH=16.
module tb_nibble_serial_adder_ctrl;
  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct {
    int           done_cyc;
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   busy_until = 0;
  bit   mon_en = 1'b0;
  exp_t sbq[$];
  logic [W-1:0] hold_sum = '0;
  logic         hold_co = 1'b0;
  logic         hold_ov = 1'b0;

  nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic sb, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                 input logic ci);
    exp_t   e;
    longint ua, ub, sa, sbv, ur, sr;
    ua  = longint'(aa);
    ub  = longint'(bb);
    sa  = longint'($signed(aa));
    sbv = longint'($signed(bb));
    if (sb) begin
      ur   = ua - ub;
      sr   = sa - sbv;
      e.co = (ua >= ub);
    end else begin
      ur   = ua + ub + longint'(ci);
      sr   = sa + sbv + longint'(ci);
      e.co = (ur >= (64'sd1 <<< W));
    end
    e.sum      = ur[W-1:0];
    e.ov       = (sr > ((64'sd1 <<< (W-1)) - 1)) || (sr < -(64'sd1 <<< (W-1)));
    e.done_cyc = 0;
    return e;
  endfunction

  // Called at a falling edge; the inputs set here are sampled at the end of this cycle.
  task automatic drive_cycle(input logic s, input logic sb, input logic [W-1:0] aa,
                             input logic [W-1:0] bb, input logic ci, input logic rst);
    exp_t e;
    bus.start = s;
    bus.sub   = sb;
    bus.a     = aa;
    bus.b     = bb;
    bus.c_in  = ci;
    reset     = rst;
    if (rst) begin
      sbq.delete();
      busy_until = 0;
      hold_sum   = '0;
      hold_co    = 1'b0;
      hold_ov    = 1'b0;
    end else if (s && cyc >= busy_until) begin
      e          = model(sb, aa, bb, ci);
      e.done_cyc = cyc + NIB + 1;
      busy_until = e.done_cyc;
      sbq.push_back(e);
    end
    @(negedge clk);
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic idle_cycle(input logic s);
    drive_cycle(s, 1'($urandom), rnd_val(), rnd_val(), 1'($urandom), 1'b0);
  endtask

  task automatic wait_done_cycle();
    for (int i = 0; i < NIB + 3 && cyc < busy_until; i++) idle_cycle(1'($urandom));
  endtask

  task automatic finish_op();
    for (int i = 0; i < NIB + 3 && cyc <= busy_until; i++) idle_cycle(1'b0);
  endtask

  task automatic op(input logic sb, input logic [W-1:0] aa, input logic [W-1:0] bb,
                    input logic ci);
    drive_cycle(1'b1, sb, aa, bb, ci, 1'b0);
    finish_op();
  endtask

  // Monitor: one check set per cycle, sampled 1 time unit after the rising edge.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      exp_t e;
      logic exp_busy;
      exp_busy = 1'b0;
      if (sbq.size() > 0) begin
        exp_busy = (cyc >= sbq[0].done_cyc - NIB) && (cyc < sbq[0].done_cyc);
      end
      chk("busy", W'(bus.busy), W'(exp_busy));
      if (sbq.size() > 0 && sbq[0].done_cyc == cyc) begin
        e = sbq.pop_front();
        chk("done", W'(bus.done), W'(1'b1));
        chk("sum", bus.sum, e.sum);
        chk("c_out", W'(bus.c_out), W'(e.co));
        chk("overflow", W'(bus.overflow), W'(e.ov));
        hold_sum = e.sum;
        hold_co  = e.co;
        hold_ov  = e.ov;
      end else begin
        chk("done_idle", W'(bus.done), W'(1'b0));
      end
      if (sbq.size() == 0) begin
        chk("hold_sum", bus.sum, hold_sum);
        chk("hold_c_out", W'(bus.c_out), W'(hold_co));
        chk("hold_overflow", W'(bus.overflow), W'(hold_ov));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.sub   = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.c_in  = 1'b0;
    @(negedge clk);
    drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    drive_cycle(1'b1, 1'b0, 16'h1111, 16'h1111, 1'b0, 1'b1);
    mon_en = 1'b1;
    idle_cycle(1'b0);

    op(1'b0, 16'h1234, 16'h4321, 1'b0);
    op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    op(1'b0, 16'hFFFF, 16'h0000, 1'b1);
    op(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    op(1'b1, 16'h8000, 16'h0001, 1'b0);
    op(1'b1, 16'h0005, 16'h0007, 1'b1);

    // start held across busy with operands changing mid-flight, then back-to-back start
    drive_cycle(1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b0, 16'h1111, 16'h2222, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 16'h9999, 16'h8888, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 16'h9999, 16'h8888, 1'b1, 1'b0);
    for (int i = 0; i < NIB + 3 && cyc < busy_until; i++) idle_cycle(1'b0);
    op(1'b1, 16'h0100, 16'h0001, 1'b0);

    // reset in the third cycle of RUN aborts; start on the reset edge is ignored
    drive_cycle(1'b1, 1'b0, 16'hABCD, 16'h1111, 1'b1, 1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    drive_cycle(1'b1, 1'b0, 16'h2222, 16'h2222, 1'b1, 1'b1);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    op(1'b0, 16'h0001, 16'h0002, 1'b0);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) finish_op();
      else                           wait_done_cycle();
      drive_cycle(1'b1, 1'($urandom), rnd_val(), rnd_val(), 1'($urandom), 1'b0);
    end
    finish_op();
    idle_cycle(1'b0);

    chk("drain", W'(sbq.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
